sps_match_controller: RTL and testbench

//   Sequences a best-of-N stone-paper-scissors match around the combinational judge.

---
 rtl/sps_match_controller_pkg.sv | 27 ++
 rtl/sps_match_controller_if.sv | 33 +++
 rtl/sps_match_controller_judge.sv | 23 ++
 rtl/sps_match_controller.sv | 157 +++++++++++++++
 tb/tb_sps_match_controller.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sps_match_controller_pkg.sv
// Shared types for the stone-paper-scissors match controller: move and result
// encodings plus the controller state encoding.
package sps_match_controller_pkg;

    typedef enum logic [1:0] {
        MoveStone    = 2'b00,
        MovePaper    = 2'b01,
        MoveScissors = 2'b10,
        MoveInvalid  = 2'b11
    } move_e;

    typedef enum logic [1:0] {
        ResTie     = 2'b00,
        ResP1      = 2'b01,
        ResP2      = 2'b10,
        ResInvalid = 2'b11
    } result_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StJudge   = 3'd2,
        StReport  = 3'd3,
        StDone    = 3'd4
    } state_e;

endpackage

// File: rtl/sps_match_controller_if.sv
// Bundle of match control, per-player move handshakes and result/score outputs.
// master = players/host side, slave = the controller.
interface sps_match_controller_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               start;
    logic               abort;
    logic               p1_valid;
    logic [1:0]         p1_move;
    logic               p1_ready;
    logic               p2_valid;
    logic [1:0]         p2_move;
    logic               p2_ready;
    logic               round_valid;
    logic [1:0]         round_result;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic               busy;
    logic               match_done;
    logic [1:0]         match_winner;

    modport master (
        output start, abort, p1_valid, p1_move, p2_valid, p2_move,
        input  p1_ready, p2_ready, round_valid, round_result, p1_score, p2_score,
               busy, match_done, match_winner
    );

    modport slave (
        input  start, abort, p1_valid, p1_move, p2_valid, p2_move,
        output p1_ready, p2_ready, round_valid, round_result, p1_score, p2_score,
               busy, match_done, match_winner
    );
endinterface

// File: rtl/sps_match_controller_judge.sv
// Combinational round judge: two 2-bit moves in, 2-bit round result out.
module sps_match_controller_judge
    import sps_match_controller_pkg::*;
(
    input  logic [1:0] p1_move_i,
    input  logic [1:0] p2_move_i,
    output logic [1:0] result_o
);

    always_comb begin
        result_o = ResP2;
        if (p1_move_i == MoveInvalid || p2_move_i == MoveInvalid) begin
            result_o = ResInvalid;
        end else if (p1_move_i == p2_move_i) begin
            result_o = ResTie;
        end else if ((p1_move_i == MoveStone    && p2_move_i == MoveScissors) ||
                     (p1_move_i == MovePaper    && p2_move_i == MoveStone)    ||
                     (p1_move_i == MoveScissors && p2_move_i == MovePaper)) begin
            result_o = ResP1;
        end
    end

endmodule

// File: rtl/sps_match_controller.sv
// Best-of-N match sequencer: collects hidden moves, judges each round, keeps
// saturating scores, forfeits a stalled player on timeout and declares the winner.
module sps_match_controller
    import sps_match_controller_pkg::*;
#(
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned SCORE_W       = 4,
    parameter int unsigned TIMEOUT_CYC   = 255,
    parameter int unsigned TO_W          = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sps_match_controller_if.slave      bus
);

    localparam logic [SCORE_W-1:0] WinScore    = SCORE_W'(ROUNDS_TO_WIN);
    localparam logic [TO_W-1:0]    TimeoutLast = TO_W'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [1:0]         p1_move_q, p1_move_d, p2_move_q, p2_move_d;
    logic               p1_have_q, p1_have_d, p2_have_q, p2_have_d;
    logic [TO_W-1:0]    timer_q, timer_d;
    logic [1:0]         result_q, result_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;

    logic [1:0] judged;
    logic [1:0] round_res;
    logic       p1_acc, p2_acc;

    sps_match_controller_judge u_judge (
        .p1_move_i (p1_move_q),
        .p2_move_i (p2_move_q),
        .result_o  (judged)
    );

    // A missing move forfeits the round to whoever did commit; nobody committed is a tie.
    assign round_res = (p1_have_q && p2_have_q) ? judged     :
                       p1_have_q                ? 2'(ResP1)  :
                       p2_have_q                ? 2'(ResP2)  : 2'(ResTie);

    assign p1_acc = (state_q == StCollect) && !p1_have_q && bus.p1_valid;
    assign p2_acc = (state_q == StCollect) && !p2_have_q && bus.p2_valid;

    always_comb begin
        state_d    = state_q;
        p1_move_d  = p1_move_q;
        p2_move_d  = p2_move_q;
        p1_have_d  = p1_have_q;
        p2_have_d  = p2_have_q;
        timer_d    = timer_q;
        result_d   = result_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;

        if (bus.abort) begin
            state_d    = StIdle;
            p1_move_d  = '0;
            p2_move_d  = '0;
            p1_have_d  = 1'b0;
            p2_have_d  = 1'b0;
            timer_d    = '0;
            result_d   = '0;
            p1_score_d = '0;
            p2_score_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_d    = StCollect;
                        p1_move_d  = '0;
                        p2_move_d  = '0;
                        p1_have_d  = 1'b0;
                        p2_have_d  = 1'b0;
                        timer_d    = '0;
                        p1_score_d = '0;
                        p2_score_d = '0;
                    end
                end
                StCollect: begin
                    if (p1_acc) begin
                        p1_move_d = bus.p1_move;
                        p1_have_d = 1'b1;
                    end
                    if (p2_acc) begin
                        p2_move_d = bus.p2_move;
                        p2_have_d = 1'b1;
                    end
                    timer_d = timer_q + 1'b1;
                    // Moves taken in the expiry cycle are already in *_have_d here.
                    if ((p1_have_d && p2_have_d) || timer_q == TimeoutLast) begin
                        state_d = StJudge;
                    end
                end
                StJudge: begin
                    result_d = round_res;
                    if (round_res == ResP1 && p1_score_q != WinScore) begin
                        p1_score_d = p1_score_q + 1'b1;
                    end
                    if (round_res == ResP2 && p2_score_q != WinScore) begin
                        p2_score_d = p2_score_q + 1'b1;
                    end
                    state_d = StReport;
                end
                StReport: begin
                    if (p1_score_q == WinScore || p2_score_q == WinScore) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StCollect;
                        p1_move_d = '0;
                        p2_move_d = '0;
                        p1_have_d = 1'b0;
                        p2_have_d = 1'b0;
                        timer_d   = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            p1_move_q  <= '0;
            p2_move_q  <= '0;
            p1_have_q  <= 1'b0;
            p2_have_q  <= 1'b0;
            timer_q    <= '0;
            result_q   <= '0;
            p1_score_q <= '0;
            p2_score_q <= '0;
        end else begin
            state_q    <= state_d;
            p1_move_q  <= p1_move_d;
            p2_move_q  <= p2_move_d;
            p1_have_q  <= p1_have_d;
            p2_have_q  <= p2_have_d;
            timer_q    <= timer_d;
            result_q   <= result_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
        end
    end

    assign bus.p1_ready     = (state_q == StCollect) && !p1_have_q;
    assign bus.p2_ready     = (state_q == StCollect) && !p2_have_q;
    assign bus.round_valid  = (state_q == StReport);
    assign bus.round_result = (state_q == StReport) ? result_q : 2'b00;
    assign bus.p1_score     = p1_score_q;
    assign bus.p2_score     = p2_score_q;
    assign bus.busy         = (state_q == StCollect) || (state_q == StJudge) ||
                              (state_q == StReport);
    assign bus.match_done   = (state_q == StDone);
    assign bus.match_winner = (state_q != StDone)       ? 2'(ResTie) :
                              (p1_score_q == WinScore)  ? 2'(ResP1)  : 2'(ResP2);

endmodule

// File: tb/tb_sps_match_controller.sv
// Directed bench for sps_match_controller with a short timeout (8 cycles).
module tb_sps_match_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sps_match_controller_if #(.SCORE_W(4)) bus ();

    sps_match_controller #(
        .ROUNDS_TO_WIN (2),
        .SCORE_W       (4),
        .TIMEOUT_CYC   (8),
        .TO_W          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 8'(bus.busy), 8'd0);
        chk({tag, "_p1rdy"}, 8'(bus.p1_ready), 8'd0);
        chk({tag, "_p2rdy"}, 8'(bus.p2_ready), 8'd0);
        chk({tag, "_rv"}, 8'(bus.round_valid), 8'd0);
        chk({tag, "_res"}, 8'(bus.round_result), 8'd0);
        chk({tag, "_p1s"}, 8'(bus.p1_score), 8'd0);
        chk({tag, "_p2s"}, 8'(bus.p2_score), 8'd0);
        chk({tag, "_done"}, 8'(bus.match_done), 8'd0);
        chk({tag, "_win"}, 8'(bus.match_winner), 8'd0);
    endtask

    task automatic moves(input logic v1, input logic [1:0] m1, input logic v2,
                         input logic [1:0] m2);
        bus.p1_valid = v1;
        bus.p1_move  = m1;
        bus.p2_valid = v2;
        bus.p2_move  = m2;
    endtask

    // Both players offer in the same cycle; ends in REPORT.
    task automatic play(input logic [1:0] m1, input logic [1:0] m2);
        moves(1'b1, m1, 1'b1, m2);
        tick();
        moves(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        moves(1'b0, 2'b00, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");

        rst_n = 1'b1;
        tick();
        chk("idle_p1rdy", 8'(bus.p1_ready), 8'd0);

        // Reset asserted in the middle of COLLECT
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("collect_busy", 8'(bus.busy), 8'd1);
        chk("collect_p1rdy", 8'(bus.p1_ready), 8'd1);
        chk("collect_p2rdy", 8'(bus.p2_ready), 8'd1);
        tick();
        #2 rst_n = 1'b0;
        #1 chk_quiet("async_rst");
        rst_n = 1'b1;
        tick();
        chk("post_rst_p1rdy", 8'(bus.p1_ready), 8'd0);
        chk("post_rst_busy", 8'(bus.busy), 8'd0);

        // Same-cycle moves: stone vs scissors, pulse two edges later
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        moves(1'b1, 2'b00, 1'b1, 2'b10);
        tick();
        moves(1'b0, 2'b00, 1'b0, 2'b00);
        chk("judge_rv", 8'(bus.round_valid), 8'd0);
        chk("judge_p1rdy", 8'(bus.p1_ready), 8'd0);
        chk("judge_res_hidden", 8'(bus.round_result), 8'd0);
        tick();
        chk("r1_rv", 8'(bus.round_valid), 8'd1);
        chk("r1_res", 8'(bus.round_result), 8'h1);
        chk("r1_p1s", 8'(bus.p1_score), 8'd1);
        chk("r1_p2s", 8'(bus.p2_score), 8'd0);
        tick();
        chk("r1_after_rv", 8'(bus.round_valid), 8'd0);
        chk("r1_after_res", 8'(bus.round_result), 8'd0);
        chk("r1_after_p1rdy", 8'(bus.p1_ready), 8'd1);
        chk("r1_after_p2rdy", 8'(bus.p2_ready), 8'd1);

        // Staggered handshakes: paper vs stone, P1 takes the match
        moves(1'b1, 2'b01, 1'b0, 2'b00);
        tick();
        chk("stag_p1rdy", 8'(bus.p1_ready), 8'd0);
        chk("stag_p2rdy", 8'(bus.p2_ready), 8'd1);
        moves(1'b0, 2'b00, 1'b1, 2'b00);
        tick();
        moves(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        chk("r2_res", 8'(bus.round_result), 8'h1);
        chk("r2_p1s", 8'(bus.p1_score), 8'd2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("done_flag", 8'(bus.match_done), 8'd1);
        chk("done_winner", 8'(bus.match_winner), 8'h1);
        chk("done_p1rdy", 8'(bus.p1_ready), 8'd0);
        chk("done_p2rdy", 8'(bus.p2_ready), 8'd0);
        chk("done_busy", 8'(bus.busy), 8'd0);
        chk("done_p1s", 8'(bus.p1_score), 8'd2);
        tick();
        chk("done_hold", 8'(bus.match_done), 8'd1);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("new_p1s", 8'(bus.p1_score), 8'd0);
        chk("new_done", 8'(bus.match_done), 8'd0);
        chk("new_winner", 8'(bus.match_winner), 8'd0);

        // Invalid move, P2 win, tie, P1 win
        play(2'b11, 2'b00);
        chk("inv_res", 8'(bus.round_result), 8'h3);
        chk("inv_p1s", 8'(bus.p1_score), 8'd0);
        chk("inv_p2s", 8'(bus.p2_score), 8'd0);
        tick();
        chk("inv_p1rdy", 8'(bus.p1_ready), 8'd1);
        chk("inv_p2rdy", 8'(bus.p2_ready), 8'd1);
        play(2'b00, 2'b01);
        chk("p2w_res", 8'(bus.round_result), 8'h2);
        chk("p2w_p2s", 8'(bus.p2_score), 8'd1);
        tick();
        play(2'b10, 2'b10);
        chk("tie_res", 8'(bus.round_result), 8'h0);
        chk("tie_rv", 8'(bus.round_valid), 8'd1);
        chk("tie_p2s", 8'(bus.p2_score), 8'd1);
        tick();
        play(2'b10, 2'b01);
        chk("p1w_res", 8'(bus.round_result), 8'h1);
        chk("p1w_p1s", 8'(bus.p1_score), 8'd1);
        tick();

        // Timeout with only P2 committed: forfeit to P2, which wins the match
        moves(1'b0, 2'b00, 1'b1, 2'b01);
        tick();
        moves(1'b0, 2'b00, 1'b0, 2'b00);
        repeat (6) tick();
        chk("to_pre_p1rdy", 8'(bus.p1_ready), 8'd1);
        chk("to_pre_busy", 8'(bus.busy), 8'd1);
        tick();
        chk("to_judge_rv", 8'(bus.round_valid), 8'd0);
        chk("to_judge_p1rdy", 8'(bus.p1_ready), 8'd0);
        tick();
        chk("to_rv", 8'(bus.round_valid), 8'd1);
        chk("to_res", 8'(bus.round_result), 8'h2);
        chk("to_p2s", 8'(bus.p2_score), 8'd2);
        tick();
        chk("to_done", 8'(bus.match_done), 8'd1);
        chk("to_winner", 8'(bus.match_winner), 8'h2);
        bus.start = 1'b1; tick(); bus.start = 1'b0;

        // P1 handshake in the expiry cycle is judged normally
        moves(1'b0, 2'b00, 1'b1, 2'b01);
        tick();
        moves(1'b0, 2'b00, 1'b0, 2'b00);
        repeat (6) tick();
        chk("exp_p1rdy", 8'(bus.p1_ready), 8'd1);
        moves(1'b1, 2'b10, 1'b0, 2'b00);
        tick();
        moves(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        chk("exp_res", 8'(bus.round_result), 8'h1);
        chk("exp_p1s", 8'(bus.p1_score), 8'd1);
        chk("exp_p2s", 8'(bus.p2_score), 8'd0);
        tick();

        // Nobody plays: timeout gives a tie
        repeat (8) tick();
        chk("none_judge_rv", 8'(bus.round_valid), 8'd0);
        tick();
        chk("none_rv", 8'(bus.round_valid), 8'd1);
        chk("none_res", 8'(bus.round_result), 8'h0);
        chk("none_p1s", 8'(bus.p1_score), 8'd1);
        tick();

        // Abort the cycle after P1 commits
        moves(1'b1, 2'b00, 1'b0, 2'b00);
        tick();
        moves(1'b0, 2'b00, 1'b0, 2'b00);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_quiet("abort");
        tick();
        chk("abort_later_rv", 8'(bus.round_valid), 8'd0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_start_busy", 8'(bus.busy), 8'd0);
        chk("abort_start_p1rdy", 8'(bus.p1_ready), 8'd0);

        // Abort coinciding with the result pulse
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        play(2'b01, 2'b00);
        bus.abort = 1'b1;
        #1;
        chk("abort_rep_rv", 8'(bus.round_valid), 8'd1);
        chk("abort_rep_res", 8'(bus.round_result), 8'h1);
        tick();
        bus.abort = 1'b0;
        chk("abort_rep_busy", 8'(bus.busy), 8'd0);
        chk("abort_rep_p1s", 8'(bus.p1_score), 8'd0);
        chk("abort_rep_after_rv", 8'(bus.round_valid), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
